button_event_unit: RTL

- Parametrised, multi-channel front end for the IO-shield push buttons; sits between the raw button pins and the game loop.
- Replaces direct use of raw buttons with:
  - synchronised, debounced levels;
  - one-cycle press and release pulses;
  - optional hold-to-repeat.
- Press and repeat events are serialised through a valid/ready event port, so the game loop consumes exactly one move per event, in priority order.

---
 rtl/button_pkg.sv | 30 +++
 rtl/btn_channel.sv | 102 ++++++++++
 rtl/button_event_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared constants for the push-button front end: 50 MHz timing defaults,
// direction indices used by the game loop and the event-kind encoding.
package button_pkg;

    localparam int NUM_BTN_DEF         = 5;
    localparam int DEBOUNCE_CYCLES_DEF = 500_000;     // 10 ms
    localparam int REPEAT_DELAY_DEF    = 25_000_000;  // 500 ms
    localparam int REPEAT_PERIOD_DEF   = 7_500_000;   // 150 ms

    localparam int UP    = 0;
    localparam int MID   = 1;
    localparam int DOWN  = 2;
    localparam int LEFT  = 3;
    localparam int RIGHT = 4;

    typedef enum logic {
        EVT_PRESS  = 1'b0,
        EVT_REPEAT = 1'b1
    } evt_kind_e;

    typedef enum logic {
        RPT_DELAY  = 1'b0,
        RPT_PERIOD = 1'b1
    } rpt_phase_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debouncer, registered
// press/release pulses and the hold-to-repeat timer.
module btn_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    input  logic repeat_on_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_fire_o
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    logic              sync1_q, sync2_q;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_terminal;
    rpt_phase_e        phase_q, phase_d;
    logic              repeat_active;
    logic              repeat_fire;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            phase_q    <= RPT_DELAY;
        end else begin
            sync1_q    <= btn_raw_i;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            phase_q    <= phase_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        deb_cnt_d = '0;
        if (sync2_q != level_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d   = sync2_q;
                press_d   = sync2_q;
                release_d = ~sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    // Hold counter reads 0 in the press cycle; after the first fire it
    // restarts at 1 so later fires land exactly REPEAT_PERIOD apart.
    assign repeat_active = repeat_on_i & level_q;
    assign hold_terminal = (phase_q == RPT_DELAY) ? HOLD_W'(REPEAT_DELAY)
                                                  : HOLD_W'(REPEAT_PERIOD);

    always_comb begin
        repeat_fire = 1'b0;
        hold_cnt_d  = '0;
        phase_d     = RPT_DELAY;
        if (repeat_active) begin
            phase_d    = phase_q;
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            if (hold_cnt_q == hold_terminal) begin
                repeat_fire = 1'b1;
                hold_cnt_d  = HOLD_W'(1);
                phase_d     = RPT_PERIOD;
            end
        end
    end

    assign level_o       = level_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign repeat_fire_o = repeat_fire;

endmodule

// File: rtl/button_event_unit.sv
// Multi-channel button front end: per-channel debounce/repeat plus a
// pending-event vector served lowest-index-first over a valid/ready port.
module button_event_unit
    import button_pkg::*;
#(
    parameter int               NUM_BTN         = NUM_BTN_DEF,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int               REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter logic [NUM_BTN-1:0] REPEAT_MASK   = '1,
    localparam int              IDX_W           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               repeat_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               evt_valid,
    output logic [IDX_W-1:0]   evt_idx,
    output logic               evt_repeat,
    input  logic               evt_ready,
    output logic               evt_dropped
);

    logic [NUM_BTN-1:0] repeat_fire;
    logic [NUM_BTN-1:0] pending_q, pending_d;
    logic [NUM_BTN-1:0] kind_q, kind_d;
    logic               dropped_q, dropped_d;
    logic [NUM_BTN-1:0] set_vec, clr_vec, lowest_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_kind;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .btn_raw_i     (btn_raw[g]),
            .repeat_on_i   (repeat_en & REPEAT_MASK[g]),
            .level_o       (btn_level[g]),
            .press_o       (btn_press[g]),
            .release_o     (btn_release[g]),
            .repeat_fire_o (repeat_fire[g])
        );
    end

    always_comb begin
        pick_idx  = '0;
        pick_kind = 1'b0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick_idx  = IDX_W'(i);
                pick_kind = kind_q[i];
            end
        end
    end

    assign lowest_oh = pending_q & (~pending_q + NUM_BTN'(1));
    assign clr_vec   = (evt_valid && evt_ready) ? lowest_oh : '0;
    assign set_vec   = btn_press | repeat_fire;

    // A set landing on a bit accepted this same cycle is a fresh event, not a collapse.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | set_vec;
        dropped_d = |(set_vec & pending_q & ~clr_vec);
        kind_d    = kind_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (set_vec[i]) begin
                kind_d[i] = btn_press[i] ? EVT_PRESS : EVT_REPEAT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            kind_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            kind_q    <= kind_d;
            dropped_q <= dropped_d;
        end
    end

    assign evt_valid   = |pending_q;
    assign evt_idx     = pick_idx;
    assign evt_repeat  = (pick_kind == EVT_REPEAT);
    assign evt_dropped = dropped_q;

endmodule
